// File: rtl/game_tick_scheduler_pkg.sv
// Shared game definitions: state encodings used by the game state machine,
// the scheduler's phase view of them, and score/level ceilings.
package game_tick_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_START        = 2'b00,
      ST_PLAYING      = 2'b01,
      ST_INSTRUCTIONS = 2'b10,
      ST_GAME_OVER    = 2'b11
   } game_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_RUN,
      PH_FROZEN
   } phase_e;

   localparam logic [9:0] SCORE_MAX = 10'd999;
   localparam logic [2:0] LEVEL_MAX = 3'd7;

   function automatic phase_e phase_of(input game_state_e st);
      case (st)
         ST_PLAYING:   return PH_RUN;
         ST_GAME_OVER: return PH_FROZEN;
         default:      return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/game_tick_scheduler_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1 (maximal length, never reaches zero
// from a nonzero seed). Free-running; reloads the seed on reset.
module lfsr8 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst) q <= seed;
      else      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   end

endmodule

// File: rtl/game_tick_scheduler.sv
// Frame-driven move/spawn scheduler with score and difficulty level tracking.
// Move period shrinks with level; spawns are requested every SPAWN_GAP moves.
module game_tick_scheduler
   import game_tick_scheduler_pkg::*;
#(
   parameter int unsigned FRAMES_L0     = 8,
   parameter int unsigned FRAMES_MIN    = 2,
   parameter int unsigned SPAWN_GAP     = 6,
   parameter int unsigned PTS_PER_LEVEL = 10,
   parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [1:0] state,
   input  logic       obstacle_passed,
   input  logic       spawn_ack,
   output logic       move_tick,
   output logic       spawn_req,
   output logic [1:0] spawn_lane,
   output logic [9:0] score,
   output logic [2:0] level
);

   localparam logic [4:0] L0_W       = 5'(FRAMES_L0);
   localparam logic [4:0] MIN_W      = 5'(FRAMES_MIN);
   localparam logic [3:0] GAP_LAST   = 4'(SPAWN_GAP - 1);
   localparam logic [5:0] PTS_LAST   = 6'(PTS_PER_LEVEL - 1);

   game_state_e state_q;
   phase_e      phase;
   logic        entry;
   logic        fire;
   logic        spawn_due;
   logic [4:0]  period;
   logic [3:0]  frame_cnt;
   logic [3:0]  move_cnt;
   logic [5:0]  pts_cnt;
   logic [7:0]  lfsr;

   lfsr8 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .q    (lfsr)
   );

   // period = max(FRAMES_L0 - level, FRAMES_MIN) without going negative
   always_comb begin
      phase     = phase_of(state_q);
      entry     = (game_state_e'(state) == ST_PLAYING) && (state_q != ST_PLAYING);
      period    = (({2'b00, level} + MIN_W) >= L0_W) ? MIN_W : (L0_W - {2'b00, level});
      fire      = (phase == PH_RUN) && frame_tick && (({1'b0, frame_cnt} + 5'd1) >= period);
      spawn_due = (phase == PH_RUN) && move_tick && (move_cnt == GAP_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_START;
         move_tick  <= 1'b0;
         spawn_req  <= 1'b0;
         spawn_lane <= 2'b00;
         score      <= '0;
         level      <= '0;
         frame_cnt  <= '0;
         move_cnt   <= '0;
         pts_cnt    <= '0;
      end else begin
         state_q   <= game_state_e'(state);
         move_tick <= fire;
         if (entry) begin
            score     <= '0;
            level     <= '0;
            frame_cnt <= '0;
            move_cnt  <= '0;
            pts_cnt   <= '0;
            spawn_req <= 1'b0;
         end else if (phase == PH_RUN) begin
            if (frame_tick)
               frame_cnt <= fire ? 4'd0 : frame_cnt + 4'd1;
            if (move_tick)
               move_cnt <= (move_cnt == GAP_LAST) ? 4'd0 : move_cnt + 4'd1;
            // A pending request blocks new spawns until it is acknowledged
            if (spawn_req) begin
               if (spawn_ack) spawn_req <= 1'b0;
            end else if (spawn_due) begin
               spawn_req  <= 1'b1;
               spawn_lane <= lfsr[1:0];
            end
            if (obstacle_passed) begin
               if (score != SCORE_MAX) score <= score + 10'd1;
               if (pts_cnt == PTS_LAST) begin
                  pts_cnt <= '0;
                  if (level != LEVEL_MAX) level <= level + 3'd1;
               end else begin
                  pts_cnt <= pts_cnt + 6'd1;
               end
            end
         end else begin
            spawn_req <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: a count-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_game_tick_scheduler;

   localparam int         FL0  = 8;
   localparam int         FMIN = 2;
   localparam int         GAP  = 6;
   localparam int         PTS  = 10;
   localparam logic [7:0] SEED = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic [1:0] state = 2'b00;
   logic       obstacle_passed = 1'b0;
   logic       spawn_ack = 1'b0;
   logic       move_tick;
   logic       spawn_req;
   logic [1:0] spawn_lane;
   logic [9:0] score;
   logic [2:0] level;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   game_tick_scheduler #(
      .FRAMES_L0     (FL0),
      .FRAMES_MIN    (FMIN),
      .SPAWN_GAP     (GAP),
      .PTS_PER_LEVEL (PTS),
      .LFSR_SEED     (SEED)
   ) dut (
      .clk             (clk),
      .rst             (rst_n),
      .frame_tick      (frame_tick),
      .state           (state),
      .obstacle_passed (obstacle_passed),
      .spawn_ack       (spawn_ack),
      .move_tick       (move_tick),
      .spawn_req       (spawn_req),
      .spawn_lane      (spawn_lane),
      .score           (score),
      .level           (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (totals since game start) ----------------
   function automatic int level_of(input int passes);
      return (passes / PTS > 7) ? 7 : passes / PTS;
   endfunction

   function automatic int score_of(input int passes);
      return (passes > 999) ? 999 : passes;
   endfunction

   function automatic int period_of(input int lvl);
      return (FL0 - lvl < FMIN) ? FMIN : FL0 - lvl;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], ^(v & 8'hB8)};
   endfunction

   int         m_frames = 0;
   int         m_moves  = 0;
   int         m_passes = 0;
   logic       m_move_tick = 1'b0;
   logic       m_spawn = 1'b0;
   logic [1:0] m_lane = 2'b00;
   logic [1:0] m_prev = 2'b00;
   logic [7:0] m_lfsr = SEED;
   bit         m_due, m_next_move;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_frames = 0; m_moves = 0; m_passes = 0;
         m_move_tick = 1'b0; m_spawn = 1'b0; m_lane = 2'b00;
         m_prev = 2'b00; m_lfsr = SEED;
      end else begin
         m_next_move = 1'b0;
         if (state == 2'b01 && m_prev != 2'b01) begin
            m_frames = 0; m_moves = 0; m_passes = 0; m_spawn = 1'b0;
         end else if (m_prev == 2'b01) begin
            if (frame_tick) begin
               m_frames++;
               if (m_frames >= period_of(level_of(m_passes))) begin
                  m_frames = 0;
                  m_next_move = 1'b1;
               end
            end
            m_due = 1'b0;
            if (m_move_tick) begin
               m_moves++;
               m_due = (m_moves % GAP) == 0;
            end
            if (m_spawn) begin
               if (spawn_ack) m_spawn = 1'b0;
            end else if (m_due) begin
               m_spawn = 1'b1;
               m_lane  = m_lfsr[1:0];
            end
            if (obstacle_passed) m_passes++;
         end else begin
            m_spawn = 1'b0;
         end
         m_move_tick = m_next_move;
         m_prev      = state;
         m_lfsr      = lfsr_next(m_lfsr);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("move_tick", 32'(move_tick), 32'(m_move_tick));
         check("spawn_req", 32'(spawn_req), 32'(m_spawn));
         if (m_spawn) check("spawn_lane", 32'(spawn_lane), 32'(m_lane));
         check("score", 32'(score), 32'(score_of(m_passes)));
         check("level", 32'(level), 32'(level_of(m_passes)));
         check("lfsr", 32'(dut.u_lfsr.q), 32'(m_lfsr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic frame_step(output logic mt);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      mt = move_tick;
      repeat (3) @(negedge clk);
   endtask

   task automatic pass_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         obstacle_passed = 1'b1;
         @(negedge clk);
         obstacle_passed = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic mt;
      int   guard;

      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_move_tick", 32'(move_tick), 32'd0);
      check("rst_spawn_req", 32'(spawn_req), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_lfsr", 32'(dut.u_lfsr.q), 32'h A5);
      rst_n = 1'b1;

      // LFSR: first step, never zero, full period of 255
      for (int i = 1; i <= 255; i++) begin
         @(negedge clk);
         if (i == 1) check("lfsr_first_step", 32'(dut.u_lfsr.q), 32'h4A);
         check("lfsr_nonzero", 32'(dut.u_lfsr.q != 8'h00), 32'd1);
      end
      check("lfsr_period", 32'(dut.u_lfsr.q), 32'hA5);

      // Level 0: one move per 8 frames, 1 cycle after the 8th
      state = 2'b01;
      repeat (2) @(negedge clk);
      for (int f = 1; f <= 8; f++) begin
         frame_step(mt);
         check($sformatf("l0_frame%0d_move", f), 32'(mt), 32'(f == 8));
      end
      check("spawn_after_move1", 32'(spawn_req), 32'd0);

      // Spawn rises on move 6, holds through dropped spawn on move 12
      for (int k = 2; k <= 12; k++) begin
         for (int f = 1; f <= 8; f++) frame_step(mt);
         check($sformatf("move%0d_fired", k), 32'(mt), 32'd1);
         check($sformatf("spawn_after_move%0d", k), 32'(spawn_req), 32'(k >= 6));
      end
      spawn_ack = 1'b1;
      @(negedge clk);
      spawn_ack = 1'b0;
      check("spawn_cleared_by_ack", 32'(spawn_req), 32'd0);
      spawn_ack = 1'b1;
      repeat (2) @(negedge clk);
      spawn_ack = 1'b0;
      check("ack_while_idle_ignored", 32'(spawn_req), 32'd0);

      // Scoring and level: period 7 at level 1
      pass_pulses(10);
      check("score_10", 32'(score), 32'd10);
      check("level_1", 32'(level), 32'd1);
      for (int f = 1; f <= 7; f++) begin
         frame_step(mt);
         check($sformatf("l1_frame%0d_move", f), 32'(mt), 32'(f == 7));
      end
      // frame_cnt left at 5, then level jumps to 6: next frame fires at once
      for (int f = 1; f <= 5; f++) begin
         frame_step(mt);
         check("l1_partial_no_move", 32'(mt), 32'd0);
      end
      pass_pulses(50);
      check("level_6", 32'(level), 32'd6);
      frame_step(mt);
      check("overshoot_fires", 32'(mt), 32'd1);
      pass_pulses(10);
      check("level_7", 32'(level), 32'd7);
      frame_step(mt);
      check("l7_frame1_move", 32'(mt), 32'd0);
      frame_step(mt);
      check("l7_frame2_move", 32'(mt), 32'd1);
      // Simultaneous frame_tick and obstacle_passed
      frame_tick = 1'b1;
      obstacle_passed = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      obstacle_passed = 1'b0;
      check("simul_no_move_frame1", 32'(move_tick), 32'd0);
      check("simul_score", 32'(score), 32'd71);
      frame_tick = 1'b1;
      obstacle_passed = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      obstacle_passed = 1'b0;
      check("simul_move_fires", 32'(move_tick), 32'd1);
      check("simul_score2", 32'(score), 32'd72);
      pass_pulses(3);
      check("level_sat_7", 32'(level), 32'd7);

      // Score saturation
      pass_pulses(998 - 75);
      check("score_998", 32'(score), 32'd998);
      pass_pulses(3);
      check("score_sat_999", 32'(score), 32'd999);

      // Freeze with a pending spawn
      guard = 0;
      while (spawn_req !== 1'b1 && guard < 40) begin
         frame_step(mt);
         guard++;
      end
      check("spawn_pending_before_freeze", 32'(spawn_req), 32'd1);
      state = 2'b11;
      repeat (2) @(negedge clk);
      check("spawn_dropped_on_freeze", 32'(spawn_req), 32'd0);
      for (int f = 1; f <= 6; f++) begin
         frame_step(mt);
         check("frozen_no_move", 32'(mt), 32'd0);
      end
      pass_pulses(3);
      check("frozen_score", 32'(score), 32'd999);
      check("frozen_level", 32'(level), 32'd7);

      // Restart clears score and level
      state = 2'b00;
      repeat (2) @(negedge clk);
      state = 2'b01;
      repeat (2) @(negedge clk);
      check("restart_score", 32'(score), 32'd0);
      check("restart_level", 32'(level), 32'd0);

      // Reset mid-handshake
      guard = 0;
      while (spawn_req !== 1'b1 && guard < 60) begin
         frame_step(mt);
         guard++;
      end
      check("spawn_pending_before_rst", 32'(spawn_req), 32'd1);
      pass_pulses(3);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_move_tick", 32'(move_tick), 32'd0);
      check("midrst_spawn_req", 32'(spawn_req), 32'd0);
      check("midrst_spawn_lane", 32'(spawn_lane), 32'd0);
      check("midrst_score", 32'(score), 32'd0);
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_lfsr", 32'(dut.u_lfsr.q), 32'hA5);
      rst_n = 1'b1;
      for (int f = 1; f <= 10; f++) frame_step(mt);
      pass_pulses(2);
      check("post_rst_score", 32'(score), 32'd2);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/game_tick_scheduler.md
GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 Parameter FRAMES_L0, default 8: frames per move tick at level 0 (valid range 2..15).
REQ-002 Parameter FRAMES_MIN, default 2: minimum frames per move tick at any level (valid range 1..FRAMES_L0).
REQ-003 Parameter SPAWN_GAP, default 6: move ticks between spawn requests (valid range 1..15).
REQ-004 Parameter PTS_PER_LEVEL, default 10: points per level increment (valid range 1..63).
REQ-005 Parameter LFSR_SEED, default 8'hA5: nonzero LFSR reset value.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 state  in  2  game state: 00 START, 01 PLAYING, 10 INSTRUCTIONS, 11 GAME_OVER.
REQ-010 obstacle_passed  in  1  one-cycle pulse when an obstacle leaves the screen.
REQ-011 spawn_ack  in  1  obstacle engine accepts the pending spawn.
REQ-012 move_tick  out  1  one-cycle pulse: advance obstacles one step.
REQ-013 spawn_req  out  1  spawn request, held until acknowledged.
REQ-014 spawn_lane  out  2  lane for the pending spawn.
REQ-015 score  out  10  binary score, 0..999.
REQ-016 level  out  3  difficulty level, 0..7.

Function
REQ-017 Phase is derived from registered state: RUN when state==01, FROZEN when state==11, IDLE otherwise.
REQ-018 Entry into PLAYING, detected as previous-cycle state!=01 and current state==01, shall clear score, level, frame_cnt, move_cnt, pts_cnt and spawn_req in that cycle.
REQ-019 In IDLE and FROZEN: no move_tick, no spawn_req, frame_tick and obstacle_passed ignored; score and level hold.
REQ-020 Period = max(FRAMES_L0 - level, FRAMES_MIN), evaluated at each frame_tick.
REQ-021 In RUN, each frame_tick increments frame_cnt. When frame_cnt+1 == period: frame_cnt<=0 and move_tick asserts for exactly the next cycle (1-cycle latency from the frame_tick).
REQ-022 On each move_tick in RUN, move_cnt increments. When move_cnt reaches SPAWN_GAP-1: move_cnt<=0 and a spawn becomes due.
REQ-023 Spawn due with spawn_req low: spawn_req<=1 and spawn_lane<=lfsr[1:0] in the same cycle.
REQ-024 Spawn due with spawn_req already high: the new spawn is dropped; the pending request and its lane are unchanged.
REQ-025 spawn_req high and spawn_ack high: spawn_req<=0 next cycle. spawn_lane is stable whenever spawn_req is high.
REQ-026 spawn_ack while spawn_req is low is ignored.
REQ-027 Leaving RUN with spawn_req high: spawn_req<=0 next cycle, with no ack required.
REQ-028 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle in all phases and never reaches zero.
REQ-029 obstacle_passed in RUN: score<=score+1, saturating at 999. pts_cnt increments.
REQ-030 When pts_cnt reaches PTS_PER_LEVEL: pts_cnt<=0 and level<=level+1, saturating at 7.
REQ-031 A level change affects the period from the next frame_tick. If frame_cnt+1 is already >= the new period at that frame_tick, move_tick fires and frame_cnt<=0.
REQ-032 obstacle_passed and frame_tick in the same cycle are both processed. The score update does not delay move_tick.

Reset
REQ-033 rst low at a clock edge shall set: move_tick=0, spawn_req=0, spawn_lane=0, score=0, level=0, all counters=0, lfsr=LFSR_SEED, registered state=00.
REQ-034 Reset mid-handshake drops spawn_req without ack; the first post-reset cycle behaves as IDLE.

Structure
REQ-035 A shared game package holds the state encodings 00/01/10/11, shared with the game state machine, and the SCORE_MAX=999 and LEVEL_MAX=7 constants.
REQ-036 The LFSR is one sub-module, lfsr8, with ports clk, rst, seed and q[7:0]. All other logic is inline.

Verification
REQ-037 state=01, FRAMES_L0=8, frame_tick every 4 cycles -> move_tick once per 8 frame_ticks, 1 cycle after the 8th.
REQ-038 SPAWN_GAP=6, spawn_ack tied low -> spawn_req rises on the 6th move_tick and holds. The 12th move_tick is dropped and spawn_lane is unchanged. Ack -> spawn_req low next cycle.
REQ-039 Ten obstacle_passed pulses -> score=10, level=1, period 7 from the next frame. 70 pulses -> level=7, period=2 (FRAMES_MIN). Further pulses leave level at 7.
REQ-040 Preload score 998, three pulses -> score=999 and holds. state 01->11 -> move_tick stops, score frozen. 11->00->01 -> score=0, level=0.
REQ-041 Pending spawn_req, then state 01->11 -> spawn_req=0 next cycle. rst low mid-run -> all outputs per REQ-033, lfsr=8'hA5.
REQ-042 Run 255 cycles from reset -> lfsr returns to 8'hA5 and is never zero.
